// File: rtl/key_emu_module.sv
// rtl/key_emu_module.sv - Emulated active-low key press with bounce bursts on press and release.
module key_emu_module #(
  parameter int HOLD_T   = 500000,
  parameter int GAP_T    = 500000,
  parameter int BOUNCE_N = 4,
  parameter int BOUNCE_T = 1000,
  parameter int CNT_W    = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic Trig_Sig,
  output logic Pin_Out,
  output logic Busy_Sig,
  output logic Done_Sig
);

  localparam int PH_W = (BOUNCE_N > 0) ? $clog2(2 * BOUNCE_N + 1) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * BOUNCE_N - 1);
  localparam logic [CNT_W-1:0] BNC_LD  = CNT_W'(BOUNCE_T - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_T - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_T - 1);

  typedef enum logic [2:0] {IDLE, FALL_BNC, HOLD, RISE_BNC, GAP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PH_W-1:0]   ph;

  // Every phase loads length-1 on entry and only moves on when cnt reaches 0,
  // so Pin_Out only toggles on phase boundaries.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      ph       <= '0;
      Pin_Out  <= 1'b1;
      Busy_Sig <= 1'b0;
      Done_Sig <= 1'b0;
    end else begin
      Done_Sig <= 1'b0;
      case (state)
        IDLE: begin
          if (Trig_Sig) begin
            Pin_Out  <= 1'b0;
            Busy_Sig <= 1'b1;
            ph       <= '0;
            if (BOUNCE_N > 0) begin
              state <= FALL_BNC;
              cnt   <= BNC_LD;
            end else begin
              state <= HOLD;
              cnt   <= HOLD_LD;
            end
          end
        end
        FALL_BNC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (ph == PH_LAST) begin
            state   <= HOLD;
            cnt     <= HOLD_LD;
            ph      <= '0;
            Pin_Out <= 1'b0;
          end else begin
            ph      <= ph + 1'b1;
            cnt     <= BNC_LD;
            Pin_Out <= ~Pin_Out;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            Pin_Out <= 1'b1;
            ph      <= '0;
            if (BOUNCE_N > 0) begin
              state <= RISE_BNC;
              cnt   <= BNC_LD;
            end else begin
              state <= GAP;
              cnt   <= GAP_LD;
            end
          end
        end
        RISE_BNC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (ph == PH_LAST) begin
            state   <= GAP;
            cnt     <= GAP_LD;
            ph      <= '0;
            Pin_Out <= 1'b1;
          end else begin
            ph      <= ph + 1'b1;
            cnt     <= BNC_LD;
            Pin_Out <= ~Pin_Out;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state    <= IDLE;
            Busy_Sig <= 1'b0;
            Done_Sig <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_emu_module.sv
// tb/tb_key_emu_module.sv - Scoreboard bench for key_emu_module with bounce and no-bounce instances.
module tb_key_emu_module;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig_a = 1'b0;
  logic trig_b = 1'b0;
  logic pin_a, busy_a, done_a;
  logic pin_b, busy_b, done_b;

  always #5 clk = ~clk;

  key_emu_module #(.HOLD_T(8), .GAP_T(4), .BOUNCE_N(2), .BOUNCE_T(3), .CNT_W(8)) dut_a (
    .CLK(clk), .RST(rst), .Trig_Sig(trig_a),
    .Pin_Out(pin_a), .Busy_Sig(busy_a), .Done_Sig(done_a)
  );

  key_emu_module #(.HOLD_T(8), .GAP_T(4), .BOUNCE_N(0), .BOUNCE_T(3), .CNT_W(8)) dut_b (
    .CLK(clk), .RST(rst), .Trig_Sig(trig_b),
    .Pin_Out(pin_b), .Busy_Sig(busy_b), .Done_Sig(done_b)
  );

  typedef struct {
    int         sel;
    int         tag;
    int         t;
    logic [2:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected {pin,busy,done} at cycle k+t for a trigger sampled at edge k.
  function automatic logic [2:0] ref_a(input int t);
    logic p, b, d;
    p = 1'b1;
    b = (t >= 1 && t <= 36);
    d = (t == 37);
    if (t >= 1 && t <= 12)       p = (((t - 1) / 3) % 2) != 0;
    else if (t >= 13 && t <= 20) p = 1'b0;
    else if (t >= 21 && t <= 32) p = (((t - 21) / 3) % 2) == 0;
    return {p, b, d};
  endfunction

  function automatic logic [2:0] ref_b(input int t);
    return {!(t >= 1 && t <= 8), (t >= 1 && t <= 12), (t == 13)};
  endfunction

  task automatic push(input int sel, input int tag, input int t, input logic [2:0] e);
    exp_t x;
    x.sel = sel;
    x.tag = tag;
    x.t   = t;
    x.exp = e;
    sb.push_back(x);
  endtask

  exp_t       mx;
  logic [2:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mx  = sb.pop_front();
      act = (mx.sel != 0) ? {pin_b, busy_b, done_b} : {pin_a, busy_a, done_a};
      checks++;
      if (act !== mx.exp) begin
        errors++;
        $display("FAIL test%0d dut%0d t=%0d {pin,busy,done} got %b want %b",
                 mx.tag, mx.sel, mx.t, act, mx.exp);
      end
    end
  end

  // mode 0: single trigger; 1: extra triggers at k+5 and k+30; 2: trigger held high.
  task automatic run_a(input int tag, input int mode, input int n);
    int t;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      t = j + 1;
      push(0, tag, t, (mode == 2) ? ref_a(((t - 1) % 37) + 1) : ref_a(t));
      case (mode)
        1:       trig_a = (t == 5 || t == 30);
        2:       trig_a = 1'b1;
        default: trig_a = 1'b0;
      endcase
    end
    trig_a = 1'b0;
  endtask

  task automatic run_b(input int tag, input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      push(1, tag, j + 1, ref_b(j + 1));
      trig_b = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int sel, input int tag, input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      push(sel, tag, j, 3'b100);
    end
  endtask

  task automatic do_reset(input int tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(0, tag, 0, 3'b100);
    push(1, tag, 0, 3'b100);
    @(posedge clk);
    #1;
    push(0, tag, 1, 3'b100);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    push(0, 1, 0, 3'b100);
    push(1, 1, 0, 3'b100);
    rst    = 1'b0;
    trig_a = 1'b1;
    run_a(10, 0, 40);

    do_reset(2);
    trig_a = 1'b1;
    run_a(20, 1, 40);

    do_reset(3);
    trig_a = 1'b1;
    run_a(30, 2, 80);

    do_reset(4);
    trig_b = 1'b1;
    run_b(40, 16);

    do_reset(5);
    trig_a = 1'b1;
    run_a(50, 0, 14);
    @(posedge clk);
    #2;
    rst = 1'b1;
    push(0, 51, 0, 3'b100);
    idle_cycles(0, 52, 3);
    rst = 1'b0;
    idle_cycles(0, 53, 4);
    trig_a = 1'b1;
    run_a(54, 0, 40);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
